// File: rtl/pll_lock_seq.sv
// PLL lock sequencer: pulses the PLL reset, waits for a synchronized lock
// indication to stay stable, then releases the downstream system reset.
// Lock timeouts are retried a bounded number of times before latching a fault.
// All outputs come straight from flops.
module pll_lock_seq #(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRY      = 3,
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          restart_req,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fault,
  output logic          lock_lost,
  output logic          restart_ack,
  output logic [RW-1:0] retry_cnt
);

  // Shared counter must reach the largest per-state terminal count minus one.
  localparam int unsigned MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_RS > TIMEOUT_CYCLES) ? MAX_RS : TIMEOUT_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            lock_lost_q, lock_lost_d;
  logic            ack_q, ack_d;
  logic            pll_rst_q, pll_rst_d;
  logic            sys_rst_q, sys_rst_d;
  logic            ready_q, ready_d;
  logic            fault_q, fault_d;
  logic [1:0]      sync_q;
  logic            locked_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  assign locked_s = sync_q[1];

  // State, counter, retry count and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      ack_q       <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      ack_q       <= ack_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_q   <= sys_rst_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so the
  // registered outputs line up with the state register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    ack_d       = 1'b0;

    unique case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_LOCK: begin
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + RW'(1);
            state_d = RESET_PLL;
          end else begin
            state_d = FAULT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STABLE: begin
        // Any glitch in lock restarts both the stability window and the timeout.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RUN: begin
        // A restart request outranks a simultaneous loss of lock.
        if (restart_req) begin
          state_d     = RESET_PLL;
          cnt_d       = '0;
          ack_d       = 1'b1;
          retry_d     = '0;
          lock_lost_d = 1'b0;
        end else if (!locked_s) begin
          state_d     = RESET_PLL;
          cnt_d       = '0;
          retry_d     = '0;
          lock_lost_d = 1'b1;
        end
      end

      FAULT: begin
        if (restart_req) begin
          state_d     = RESET_PLL;
          cnt_d       = '0;
          ack_d       = 1'b1;
          retry_d     = '0;
          lock_lost_d = 1'b0;
        end
      end

      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign restart_ack = ack_q;
  assign retry_cnt   = retry_q;

endmodule
